// File: rtl/oled_pwr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : oled_pwr_seq
//  Purpose  : Power and initialisation sequencer for a 128x32 SSD1306 OLED.
//             Drives the panel supply enables (VDD, VBAT) and the reset line
//             (RES) with the SSD1306 power-up timing. Sends the fixed
//             initialisation command list to the SPI byte shifter, then
//             passes user command/data bytes through. Owns the DC line.
//  Ports    : s00_axi_aclk / s00_axi_areset : clock, async active-high reset
//             pwr_on                         : level request, 1 = panel on
//             ready                          : high while the user path is open
//             usr_valid/usr_ready/usr_byte/usr_dc : user byte stream
//             spi_valid/spi_ready/spi_byte   : byte stream to the SPI shifter
//             DC, RES, VDD, VBAT             : panel pins (RES/VDD/VBAT active-low)
//  Config   : OLED_SEQ_PWRDN_EN - when defined, pwr_on=0 in READY runs the
//             power-down path (display off, VBAT off, wait, VDD off).
//  Revision : 1.0 - initial release
// ============================================================================
module oled_pwr_seq #(
    parameter int unsigned T_VDD_CYC  = 100000,
    parameter int unsigned T_RES_CYC  = 300,
    parameter int unsigned T_VBAT_CYC = 10000000
) (
    input  logic       s00_axi_aclk,
    input  logic       s00_axi_areset,
    input  logic       pwr_on,
    output logic       ready,
    input  logic       usr_valid,
    output logic       usr_ready,
    input  logic [7:0] usr_byte,
    input  logic       usr_dc,
    output logic       spi_valid,
    input  logic       spi_ready,
    output logic [7:0] spi_byte,
    output logic       DC,
    output logic       RES,
    output logic       VDD,
    output logic       VBAT
);

    localparam logic [3:0] c_st_off       = 4'd0;
    localparam logic [3:0] c_st_vdd_wait  = 4'd1;
    localparam logic [3:0] c_st_res_lo    = 4'd2;
    localparam logic [3:0] c_st_res_hi    = 4'd3;
    localparam logic [3:0] c_st_cmd_pre   = 4'd4;
    localparam logic [3:0] c_st_vbat_wait = 4'd5;
    localparam logic [3:0] c_st_cmd_post  = 4'd6;
    localparam logic [3:0] c_st_ready     = 4'd7;
`ifdef OLED_SEQ_PWRDN_EN
    localparam logic [3:0] c_st_pd_cmd    = 4'd8;
    localparam logic [3:0] c_st_pd_wait   = 4'd9;
`endif

    // Counter reload values: a state lasting T cycles loads T-1 on entry
    // and exits on the cycle the counter reads zero.
    localparam logic [23:0] c_vdd_load  = 24'(T_VDD_CYC - 1);
    localparam logic [23:0] c_res_load  = 24'(T_RES_CYC - 1);
    localparam logic [23:0] c_vbat_load = 24'(T_VBAT_CYC - 1);

    logic [3:0]  r_state, w_state_nxt;
    logic [23:0] r_cnt,   w_cnt_nxt;
    logic [2:0]  r_idx,   w_idx_nxt;
    logic        r_dc,    w_dc_nxt;
    logic        r_res,   w_res_nxt;
    logic        r_vdd,   w_vdd_nxt;
    logic        r_vbat,  w_vbat_nxt;
    logic [7:0]  w_cmd_byte;
    logic        w_cmd_last;
    logic        w_cnt_zero;

    assign w_cnt_zero = (r_cnt == 24'd0);

    // Fixed command lists, indexed by the registered byte index so the
    // presented byte cannot change while the shifter is stalling.
    always_comb begin
        w_cmd_byte = 8'h00;
        w_cmd_last = 1'b0;
        if (r_state == c_st_cmd_pre) begin
            w_cmd_last = (r_idx == 3'd4);
            case (r_idx)
                3'd0:    w_cmd_byte = 8'hAE;
                3'd1:    w_cmd_byte = 8'h8D;
                3'd2:    w_cmd_byte = 8'h14;
                3'd3:    w_cmd_byte = 8'hD9;
                default: w_cmd_byte = 8'hF1;
            endcase
        end else if (r_state == c_st_cmd_post) begin
            w_cmd_last = (r_idx == 3'd6);
            case (r_idx)
                3'd0:    w_cmd_byte = 8'h81;
                3'd1:    w_cmd_byte = 8'h0F;
                3'd2:    w_cmd_byte = 8'hA1;
                3'd3:    w_cmd_byte = 8'hC8;
                3'd4:    w_cmd_byte = 8'hDA;
                3'd5:    w_cmd_byte = 8'h20;
                default: w_cmd_byte = 8'hAF;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dc_nxt    = r_dc;
        w_res_nxt   = r_res;
        w_vdd_nxt   = r_vdd;
        w_vbat_nxt  = r_vbat;
        ready       = 1'b0;
        usr_ready   = 1'b0;
        spi_valid   = 1'b0;
        spi_byte    = 8'h00;

        case (r_state)
            c_st_off: begin
                if (pwr_on) begin
                    // RES is taken high here so the reset pulse that follows
                    // VDD_WAIT is a clean low pulse of exactly T_RES_CYC.
                    w_state_nxt = c_st_vdd_wait;
                    w_vdd_nxt   = 1'b0;
                    w_res_nxt   = 1'b1;
                    w_cnt_nxt   = c_vdd_load;
                end
            end
            c_st_vdd_wait: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_st_res_lo;
                    w_res_nxt   = 1'b0;
                    w_cnt_nxt   = c_res_load;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            c_st_res_lo: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_st_res_hi;
                    w_res_nxt   = 1'b1;
                    w_cnt_nxt   = c_res_load;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            c_st_res_hi: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_st_cmd_pre;
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            c_st_cmd_pre, c_st_cmd_post: begin
                spi_valid = 1'b1;
                spi_byte  = w_cmd_byte;
                if (spi_ready) begin
                    w_dc_nxt  = 1'b0;
                    w_idx_nxt = r_idx + 3'd1;
                    if (w_cmd_last) begin
                        w_idx_nxt = 3'd0;
                        if (r_state == c_st_cmd_pre) begin
                            w_state_nxt = c_st_vbat_wait;
                            w_vbat_nxt  = 1'b0;
                            w_cnt_nxt   = c_vbat_load;
                        end else begin
                            w_state_nxt = c_st_ready;
                        end
                    end
                end
            end
            c_st_vbat_wait: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_st_cmd_post;
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            c_st_ready: begin
                ready     = 1'b1;
                spi_valid = usr_valid;
                spi_byte  = usr_byte;
                usr_ready = spi_ready;
                if (usr_valid && spi_ready) begin
                    // An accepted byte always completes; power-down waits
                    // for a cycle with no transfer.
                    w_dc_nxt = usr_dc;
                end
`ifdef OLED_SEQ_PWRDN_EN
                else if (!pwr_on) begin
                    w_state_nxt = c_st_pd_cmd;
                end
`endif
            end
`ifdef OLED_SEQ_PWRDN_EN
            c_st_pd_cmd: begin
                spi_valid = 1'b1;
                spi_byte  = 8'hAE;
                if (spi_ready) begin
                    w_dc_nxt    = 1'b0;
                    w_state_nxt = c_st_pd_wait;
                    w_vbat_nxt  = 1'b1;
                    w_cnt_nxt   = c_vbat_load;
                end
            end
            c_st_pd_wait: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_st_off;
                    w_vdd_nxt   = 1'b1;
                    w_res_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
`endif
            default: begin
                w_state_nxt = c_st_off;
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_state <= c_st_off;
            r_cnt   <= 24'd0;
            r_idx   <= 3'd0;
            r_dc    <= 1'b0;
            r_res   <= 1'b0;
            r_vdd   <= 1'b1;
            r_vbat  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_dc    <= w_dc_nxt;
            r_res   <= w_res_nxt;
            r_vdd   <= w_vdd_nxt;
            r_vbat  <= w_vbat_nxt;
        end
    end

    assign DC   = r_dc;
    assign RES  = r_res;
    assign VDD  = r_vdd;
    assign VBAT = r_vbat;

endmodule
`default_nettype wire

// File: tb/tb_oled_pwr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oled_pwr_seq
//  Purpose  : Self-checking bench for oled_pwr_seq. Expected command/data
//             bytes are queued when stimulus starts and popped on each
//             accepted transfer. Timing expectations come from the
//             bench-side parameters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oled_pwr_seq;

    localparam int T_VDD  = 10;
    localparam int T_RES  = 3;
    localparam int T_VBAT = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwr_on;
    logic       ready;
    logic       usr_valid;
    logic       usr_ready;
    logic [7:0] usr_byte;
    logic       usr_dc;
    logic       spi_valid;
    logic       spi_ready;
    logic [7:0] spi_byte;
    logic       DC, RES, VDD, VBAT;

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] sb [$];
    logic [7:0] init_bytes [12];

    always #5 clk = ~clk;

    oled_pwr_seq #(
        .T_VDD_CYC  (T_VDD),
        .T_RES_CYC  (T_RES),
        .T_VBAT_CYC (T_VBAT)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .pwr_on         (pwr_on),
        .ready          (ready),
        .usr_valid      (usr_valid),
        .usr_ready      (usr_ready),
        .usr_byte       (usr_byte),
        .usr_dc         (usr_dc),
        .spi_valid      (spi_valid),
        .spi_ready      (spi_ready),
        .spi_byte       (spi_byte),
        .DC             (DC),
        .RES            (RES),
        .VDD            (VDD),
        .VBAT           (VBAT)
    );

    task automatic do_reset();
        rst = 1'b1; pwr_on = 1'b0; usr_valid = 1'b0; usr_byte = 8'h00;
        usr_dc = 1'b0; spi_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic load_init_sb();
        sb.delete();
        for (int i = 0; i < 12; i++) sb.push_back({1'b0, init_bytes[i]});
    endtask

    task automatic test_reset();
        rst = 1'b1; pwr_on = 1'b0; usr_valid = 1'b0; usr_byte = 8'h00;
        usr_dc = 1'b0; spi_ready = 1'b1;
        #2;
        n_vec++;
        if ({VDD, VBAT, RES, DC} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_pins got VDD,VBAT,RES,DC=%b%b%b%b want 1100", VDD, VBAT, RES, DC);
        end
        n_vec++;
        if ({spi_valid, spi_byte, usr_ready, ready} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_hs got spi_valid=%b spi_byte=%h usr_ready=%b ready=%b want all 0",
                     spi_valid, spi_byte, usr_ready, ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_power_up();
        logic [8:0] e;
        int first_k, vbat_idle;
        bit done;
        do_reset();
        load_init_sb();
        pwr_on = 1'b1;
        @(negedge clk);
        n_vec++;
        if (VDD !== 1'b1) begin
            n_err++; $display("FAIL pwrup_vdd_early got VDD=%b want 1", VDD);
        end
        @(posedge clk);
        first_k = 0; vbat_idle = 0; done = 1'b0;
        for (int k = 1; k <= 200 && !done; k++) begin
            @(negedge clk);
            if (k <= T_VDD + 2 * T_RES) begin
                n_vec++;
                if (VDD !== 1'b0 || RES !== ((k > T_VDD && k <= T_VDD + T_RES) ? 1'b0 : 1'b1)) begin
                    n_err++;
                    $display("FAIL pwrup_vdd_res k=%0d got VDD=%b RES=%b", k, VDD, RES);
                end
            end
            if (VBAT === 1'b0 && spi_valid === 1'b0) vbat_idle++;
            if (spi_valid === 1'b1 && spi_ready === 1'b1) begin
                if (first_k == 0) first_k = k;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL pwrup_extra_byte got %h want none", spi_byte);
                end else begin
                    e = sb.pop_front();
                    if (spi_byte !== e[7:0]) begin
                        n_err++; $display("FAIL pwrup_byte got %h want %h", spi_byte, e[7:0]);
                    end
                    if (sb.size() == 0) done = 1'b1;
                end
            end
        end
        @(negedge clk);
        n_vec++;
        if (!done || ready !== 1'b1 || DC !== 1'b0) begin
            n_err++; $display("FAIL pwrup_ready got done=%b ready=%b DC=%b want 1 1 0", done, ready, DC);
        end
        n_vec++;
        if (first_k != T_VDD + 2 * T_RES + 1) begin
            n_err++; $display("FAIL pwrup_first_byte got cycle %0d want %0d", first_k, T_VDD + 2 * T_RES + 1);
        end
        n_vec++;
        if (vbat_idle != T_VBAT) begin
            n_err++; $display("FAIL pwrup_vbat_wait got %0d want %0d", vbat_idle, T_VBAT);
        end
    endtask

    task automatic test_pass_through();
        logic [8:0] items [2];
        logic [8:0] e;
        logic prev_dc;
        items[0] = 9'h140; items[1] = 9'h0B0;
        prev_dc = 1'b0;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            usr_valid = 1'b1; usr_byte = items[i][7:0]; usr_dc = items[i][8]; spi_ready = 1'b0;
            sb.push_back(items[i]);
            @(negedge clk);
            n_vec++;
            if (usr_ready !== 1'b0 || spi_valid !== 1'b1 || spi_byte !== items[i][7:0] || DC !== prev_dc) begin
                n_err++;
                $display("FAIL pt_stall got usr_ready=%b spi_valid=%b spi_byte=%h DC=%b want 0 1 %h %b",
                         usr_ready, spi_valid, spi_byte, DC, items[i][7:0], prev_dc);
            end
            @(posedge clk); #1;
            spi_ready = 1'b1;
            @(negedge clk);
            n_vec++;
            if (usr_ready !== 1'b1) begin
                n_err++; $display("FAIL pt_usr_ready got %b want 1", usr_ready);
            end
            if (usr_valid === 1'b1 && usr_ready === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (spi_byte !== e[7:0]) begin
                    n_err++; $display("FAIL pt_byte got %h want %h", spi_byte, e[7:0]);
                end
            end
            @(posedge clk); #1;
            usr_valid = 1'b0;
            @(negedge clk);
            n_vec++;
            if (DC !== items[i][8]) begin
                n_err++; $display("FAIL pt_dc got %b want %b", DC, items[i][8]);
            end
            prev_dc = items[i][8];
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL pt_leftover got %0d bytes want 0", sb.size());
        end
    endtask

`ifdef OLED_SEQ_PWRDN_EN
    task automatic test_power_down();
        logic [8:0] e;
        int gap;
        bit vdd_up;
        sb.delete();
        spi_ready = 1'b1;
        @(posedge clk); #1;
        pwr_on = 1'b0;
        sb.push_back(9'h0AE);
        @(negedge clk);
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++; $display("FAIL pd_ready_hold got %b want 1", ready);
        end
        @(negedge clk);
        n_vec++;
        if (ready !== 1'b0 || spi_valid !== 1'b1) begin
            n_err++; $display("FAIL pd_enter got ready=%b spi_valid=%b want 0 1", ready, spi_valid);
        end
        gap = 0; vdd_up = 1'b0;
        for (int k = 0; k < 100 && !vdd_up; k++) begin
            if (spi_valid === 1'b1 && spi_ready === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL pd_extra_byte got %h want none", spi_byte);
                end else begin
                    e = sb.pop_front();
                    if (spi_byte !== e[7:0]) begin
                        n_err++; $display("FAIL pd_byte got %h want %h", spi_byte, e[7:0]);
                    end
                end
            end
            if (VBAT === 1'b1 && VDD === 1'b0) gap++;
            if (VDD === 1'b1) vdd_up = 1'b1;
            else @(negedge clk);
        end
        n_vec++;
        if (gap != T_VBAT || sb.size() != 0) begin
            n_err++; $display("FAIL pd_vbat_to_vdd got %0d cycles (%0d left) want %0d", gap, sb.size(), T_VBAT);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if ({VDD, VBAT, RES, DC, ready, spi_valid} !== 6'b110000) begin
            n_err++;
            $display("FAIL pd_off got VDD,VBAT,RES,DC,ready,spi_valid=%b%b%b%b%b%b want 110000",
                     VDD, VBAT, RES, DC, ready, spi_valid);
        end
    endtask
`else
    task automatic test_macro_off();
        @(posedge clk); #1;
        pwr_on = 1'b0;
        repeat (T_VBAT + 10) @(negedge clk);
        n_vec++;
        if (ready !== 1'b1 || VBAT !== 1'b0 || VDD !== 1'b0 || spi_valid !== 1'b0) begin
            n_err++;
            $display("FAIL nopd_hold got ready=%b VBAT=%b VDD=%b spi_valid=%b want 1 0 0 0",
                     ready, VBAT, VDD, spi_valid);
        end
        pwr_on = 1'b1;
    endtask
`endif

    task automatic test_backpressure();
        logic [8:0] e;
        logic [7:0] held;
        bit held_v, done;
        do_reset();
        load_init_sb();
        pwr_on = 1'b1;
        held_v = 1'b0; done = 1'b0; held = 8'h00;
        for (int it = 0; it < 3000 && !done; it++) begin
            @(negedge clk);
            if (held_v) begin
                n_vec++;
                if (spi_valid !== 1'b1 || spi_byte !== held) begin
                    n_err++; $display("FAIL bp_stable got valid=%b byte=%h want 1 %h", spi_valid, spi_byte, held);
                end
            end
            held_v = 1'b0;
            if (spi_valid === 1'b1 && spi_ready === 1'b0) begin
                held_v = 1'b1; held = spi_byte;
            end
            if (spi_valid === 1'b1 && spi_ready === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL bp_extra_byte got %h want none", spi_byte);
                end else begin
                    e = sb.pop_front();
                    if (spi_byte !== e[7:0]) begin
                        n_err++; $display("FAIL bp_byte got %h want %h", spi_byte, e[7:0]);
                    end
                    if (sb.size() == 0) done = 1'b1;
                end
            end
            @(posedge clk); #1;
            spi_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        n_vec++;
        if (!done || ready !== 1'b1) begin
            n_err++; $display("FAIL bp_ready got done=%b ready=%b want 1 1", done, ready);
        end
        spi_ready = 1'b1;
    endtask

    task automatic test_pwroff_during_init();
        logic [8:0] e;
        bit done;
        do_reset();
        load_init_sb();
        pwr_on = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (VBAT === 1'b0) pwr_on = 1'b0;
            if (spi_valid === 1'b1 && spi_ready === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL early_off_extra got %h want none", spi_byte);
                end else begin
                    e = sb.pop_front();
                    if (spi_byte !== e[7:0]) begin
                        n_err++; $display("FAIL early_off_byte got %h want %h", spi_byte, e[7:0]);
                    end
                    if (sb.size() == 0) done = 1'b1;
                end
            end
        end
        @(negedge clk);
        n_vec++;
        if (!done || ready !== 1'b1 || pwr_on !== 1'b0) begin
            n_err++; $display("FAIL early_off_ready got done=%b ready=%b want 1 1", done, ready);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        pwr_on = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (VBAT === 1'b0) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++; $display("FAIL arst_reach_vbat got VBAT=%b want 0 within budget", VBAT);
        end
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({VBAT, VDD, RES, spi_valid, ready} !== 5'b11000) begin
            n_err++;
            $display("FAIL arst_async got VBAT,VDD,RES,spi_valid,ready=%b%b%b%b%b want 11000",
                     VBAT, VDD, RES, spi_valid, ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (VDD !== 1'b1) begin
            n_err++; $display("FAIL arst_off got VDD=%b want 1", VDD);
        end
        @(posedge clk);
        for (int k = 1; k <= T_VDD + 1; k++) begin
            @(negedge clk);
            n_vec++;
            if (VDD !== 1'b0 || RES !== ((k <= T_VDD) ? 1'b1 : 1'b0) || spi_valid !== 1'b0) begin
                n_err++;
                $display("FAIL arst_restart k=%0d got VDD=%b RES=%b spi_valid=%b", k, VDD, RES, spi_valid);
            end
        end
    endtask

    initial begin
        init_bytes = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1,
                       8'h81, 8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
        test_reset();
        test_power_up();
        test_pass_through();
`ifdef OLED_SEQ_PWRDN_EN
        test_power_down();
`else
        test_macro_off();
`endif
        test_backpressure();
        test_pwroff_during_init();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
